// File: rtl/bist_tpg.sv
// LFSR test pattern generator for the LBIST loop: one pseudo-random pattern per
// clock while running, tpg_end on the last pattern of a sweep, sweeps counted.
module bist_tpg #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0] SEED         = 8'h01,
  parameter int               NUM_PATTERNS = 255,
  parameter int               CNT_BITS     = 8,
  parameter int               SWEEP_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tpg_reset,
  input  logic                  inc,
  output logic [WIDTH-1:0]      pattern,
  output logic                  pattern_valid,
  output logic [CNT_BITS-1:0]   pattern_idx,
  output logic                  tpg_end,
  output logic [SWEEP_BITS-1:0] sweep_cnt
);

  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [WIDTH-1:0]    SEED_EFF      = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [CNT_BITS-1:0] LAST_IDX      = CNT_BITS'(NUM_PATTERNS - 1);
  localparam logic                FIRST_IS_LAST = (NUM_PATTERNS == 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        pattern_d;
  logic [CNT_BITS-1:0]     idx_d;
  logic                    valid_d;
  logic                    end_d;
  logic [SWEEP_BITS-1:0]   sweep_d;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [SWEEP_BITS-1:0] sat_inc(input logic [SWEEP_BITS-1:0] c);
    return (&c) ? c : c + SWEEP_BITS'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern;
    idx_d     = pattern_idx;
    valid_d   = 1'b0;
    end_d     = 1'b0;
    sweep_d   = sweep_cnt;
    if (tpg_reset) begin
      state_d   = IDLE;
      pattern_d = SEED_EFF;
      idx_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = RUN;
          pattern_d = SEED_EFF;
          idx_d     = '0;
          valid_d   = 1'b1;
          end_d     = FIRST_IS_LAST;
        end
        RUN: begin
          if (tpg_end) begin
            // The sweep is counted here, so a later inc from DONE must not count it again.
            sweep_d = sat_inc(sweep_cnt);
            if (inc) begin
              pattern_d = SEED_EFF;
              idx_d     = '0;
              valid_d   = 1'b1;
              end_d     = FIRST_IS_LAST;
            end else begin
              state_d = DONE;
            end
          end else begin
            pattern_d = lfsr_step(pattern);
            idx_d     = pattern_idx + CNT_BITS'(1);
            valid_d   = 1'b1;
            end_d     = ((pattern_idx + CNT_BITS'(1)) == LAST_IDX);
          end
        end
        DONE: begin
          if (inc) begin
            state_d   = RUN;
            pattern_d = SEED_EFF;
            idx_d     = '0;
            valid_d   = 1'b1;
            end_d     = FIRST_IS_LAST;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pattern       <= SEED_EFF;
      pattern_idx   <= '0;
      pattern_valid <= 1'b0;
      tpg_end       <= 1'b0;
      sweep_cnt     <= '0;
    end else begin
      state_q       <= state_d;
      pattern       <= pattern_d;
      pattern_idx   <= idx_d;
      pattern_valid <= valid_d;
      tpg_end       <= end_d;
      sweep_cnt     <= sweep_d;
    end
  end

endmodule
